// File: rtl/vga_rd_prefetch_if.sv
// Bus bundle for the VGA read prefetcher: DDR burst-read port plus display-side FIFO read port.
interface vga_rd_prefetch_if #(
  parameter int ADDR_W = 24,
  parameter int DEPTH  = 64
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic                   rd_en;
  logic [31:0]            rd_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   underflow;

  // master = prefetcher, slave = memory controller + display stage
  modport master (
    output mem_req, mem_addr, rd_data, fifo_level, underflow,
    input  mem_ack, mem_rvalid, mem_rdata, rd_en
  );
  modport slave (
    input  mem_req, mem_addr, rd_data, fifo_level, underflow,
    output mem_ack, mem_rvalid, mem_rdata, rd_en
  );
endinterface

// File: rtl/vga_rd_prefetch.sv
// Frame prefetcher: fetches one frame of pixel words from DDR in fixed bursts into a
// show-ahead FIFO feeding the display stage; restarts on every frame_sync rising edge.
module vga_rd_prefetch #(
  parameter int          ADDR_W      = 24,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int          FRAME_WORDS = 153600,
  parameter int          BURST_LEN   = 16,
  parameter int          DEPTH       = 64
) (
  input  logic vga_clk,
  input  logic vga_rst,
  input  logic ddr_init_done,
  input  logic frame_sync,
  vga_rd_prefetch_if.master bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
  localparam int BEAT_W = $clog2(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_CHECK, S_REQ, S_DATA, S_DONE, S_DRAIN
  } state_t;

  state_t            state, state_n;
  logic              fs_q;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  word_cnt;
  logic [BEAT_W-1:0] beat_cnt;

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
  logic [LVL_W-1:0]  level, level_n;
  logic [31:0]       rd_data, rd_data_n;
  logic              underflow;

  logic fs_rise, last_beat, has_space, frame_done, flush, do_wr, do_rd;

  assign fs_rise    = frame_sync & ~fs_q;
  assign last_beat  = bus.mem_rvalid && (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign has_space  = level <= LVL_W'(DEPTH - BURST_LEN);
  assign frame_done = word_cnt == CNT_W'(FRAME_WORDS);
  assign flush      = state == S_FLUSH;
  assign do_wr      = (state == S_DATA) && bus.mem_rvalid && (level != LVL_W'(DEPTH));
  assign do_rd      = bus.rd_en && (level != '0);

  assign bus.mem_req    = state == S_REQ;
  assign bus.mem_addr   = addr;
  assign bus.rd_data    = rd_data;
  assign bus.fifo_level = level;
  assign bus.underflow  = underflow;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (fs_rise) state_n = S_FLUSH;
      S_FLUSH: state_n = S_CHECK;
      S_CHECK: begin
        if (fs_rise)         state_n = S_FLUSH;
        else if (frame_done) state_n = S_DONE;
        else if (has_space)  state_n = S_REQ;
      end
      S_REQ: begin
        // An accepted burst must be drained even if the frame restarts in the same cycle.
        if (bus.mem_ack)  state_n = fs_rise ? S_DRAIN : S_DATA;
        else if (fs_rise) state_n = S_FLUSH;
      end
      S_DATA: begin
        if (fs_rise)        state_n = last_beat ? S_FLUSH : S_DRAIN;
        else if (last_beat) state_n = S_CHECK;
      end
      S_DRAIN: if (last_beat) state_n = S_FLUSH;
      S_DONE:  if (fs_rise) state_n = S_FLUSH;
      default: state_n = S_IDLE;
    endcase
    if (!ddr_init_done) state_n = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      state    <= S_IDLE;
      fs_q     <= 1'b1;  // a frame already active at reset is not a fresh start
      addr     <= ADDR_W'(BASE_ADDR);
      word_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      fs_q  <= frame_sync;
      if (flush) begin
        addr     <= ADDR_W'(BASE_ADDR);
        word_cnt <= '0;
      end
      if (state == S_REQ) beat_cnt <= '0;
      else if ((state == S_DATA || state == S_DRAIN) && bus.mem_rvalid) beat_cnt <= beat_cnt + 1'b1;
      if (state == S_DATA && last_beat) begin
        addr     <= addr + ADDR_W'(BURST_LEN);
        word_cnt <= word_cnt + CNT_W'(BURST_LEN);
      end
    end
  end

  // Next head word: zero when the FIFO empties, the incoming beat when it lands in an
  // otherwise-empty FIFO, else the stored word at the advanced read pointer.
  always_comb begin
    rd_ptr_n  = rd_ptr + PTR_W'(do_rd);
    level_n   = level + LVL_W'(do_wr) - LVL_W'(do_rd);
    rd_data_n = '0;
    if (level_n == '0)            rd_data_n = '0;
    else if (level == LVL_W'(do_rd)) rd_data_n = bus.mem_rdata;
    else                          rd_data_n = mem[rd_ptr_n];
  end

  always_ff @(posedge vga_clk) begin
    if (vga_rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_data   <= '0;
      underflow <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(do_wr);
      rd_ptr  <= rd_ptr_n;
      level   <= level_n;
      rd_data <= rd_data_n;
      if (bus.rd_en && level == '0) underflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the level counter marks what is valid.
  always_ff @(posedge vga_clk) begin
    if (do_wr) mem[wr_ptr] <= bus.mem_rdata;
  end
endmodule
